// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
// Holds the FSM state encoding, the default bus widths and the guard counter sizing.
package mips_mem_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_D_GRANTS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_t;

  // Wide enough to hold the value MAX_D_GRANTS itself, not just MAX_D_GRANTS-1.
  function automatic int cnt_width(input int max_grants);
    return (max_grants < 1) ? 1 : $clog2(max_grants + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(MAX_D_GRANTS_DEF);

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the IF-stage, MEM-stage and memory-side signals around the arbiter.
// master = arbiter view (drives memory and responses), slave = pipeline/memory view.
interface unified_mem_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;

  logic              stall_if;
  logic              stall_mem;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, dm_rdata, dm_done, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, dm_rdata, dm_done, stall_if, stall_mem,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_starve_guard.sv
// Starvation guard: counts data grants made while IF waits and forces an IF grant at the limit.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_guard
  import mips_mem_pkg::*;
#(
  parameter int MAX_D_GRANTS = MAX_D_GRANTS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic if_req,
  input  logic grant_d,
  input  logic grant_i,
  output logic force_if
);

  localparam int CNT_W = cnt_width(MAX_D_GRANTS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_GRANTS);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (grant_i || (in_idle && !if_req)) begin
      cnt_q <= '0;
    end else if (grant_d && if_req && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_if = if_req && (cnt_q == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between IF and MEM stages; MEM has priority, done pulses are registered.
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_GRANTS = MAX_D_GRANTS_DEF
) (
  input logic                    clk,
  input logic                    rst,
  unified_mem_arbiter_if.master  bus
);

  arb_state_t        state_q, state_d;
  logic              grant_i, grant_d, force_if, dm_pend;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_done_q, dm_done_q;

  assign dm_pend = bus.dm_read | bus.dm_write;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_guard #(
    .MAX_D_GRANTS (MAX_D_GRANTS)
  ) u_starve_guard (
    .clk      (clk),
    .rst      (rst),
    .in_idle  (state_q == ST_IDLE),
    .if_req   (bus.if_req),
    .grant_d  (grant_d),
    .grant_i  (grant_i),
    .force_if (force_if)
  );
`else
  logic unused_guard_cfg;
  assign unused_guard_cfg = (MAX_D_GRANTS > 0);
  assign force_if         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // force_if is only ever high together with if_req, so the else-branch grants IF.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dm_pend && !force_if) begin
          state_d = ST_BUSY_D;
          grant_d = 1'b1;
        end else if (bus.if_req) begin
          state_d = ST_BUSY_I;
          grant_i = 1'b1;
        end
      end
      ST_BUSY_I: if (bus.mem_ready) state_d = ST_RESP_I;
      ST_BUSY_D: if (bus.mem_ready) state_d = ST_RESP_D;
      ST_RESP_I,
      ST_RESP_D: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      if_done_q <= (state_q == ST_BUSY_I) && bus.mem_ready;
      dm_done_q <= (state_q == ST_BUSY_D) && bus.mem_ready;

      // A read+write request is a store: mem_we follows dm_write alone.
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.dm_write;
        mem_addr_q  <= bus.dm_addr;
        mem_wdata_q <= bus.dm_wdata;
      end else if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
      end else if (((state_q == ST_BUSY_I) || (state_q == ST_BUSY_D)) && bus.mem_ready) begin
        mem_req_q   <= 1'b0;
        mem_we_q    <= 1'b0;
      end

      if ((state_q == ST_BUSY_I) && bus.mem_ready)
        if_rdata_q <= bus.mem_rdata;
      if ((state_q == ST_BUSY_D) && bus.mem_ready && !mem_we_q)
        dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.stall_if  = bus.if_req && !if_done_q;
  assign bus.stall_mem = dm_pend && !dm_done_q;

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequential arbiter sharing one single-ported unified instruction/data memory between the pipelined MIPS core's IF stage and MEM stage. Each stage's request is granted in turn. The arbiter drives the memory with a hold-until-ready handshake, registers the read data back to the winning stage, and produces per-stage stall signals for the hazard/pipeline-register logic. The MEM stage (the older instruction) has priority, with an optional starvation guard for IF.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data word width
- MAX_D_GRANTS, 4, consecutive data grants allowed while IF is waiting (starvation guard only)
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- if_req  input  1  IF stage requests an instruction read
- if_addr  input  ADDR_W  instruction address (PC)
- if_rdata  output  DATA_W  fetched instruction, registered
- if_done  output  1  one-cycle pulse: if_rdata valid
- dm_read  input  1  MEM stage load request (MemRead)
- dm_write  input  1  MEM stage store request (MemWrite)
- dm_addr  input  ADDR_W  data address (ALU result)
- dm_wdata  input  DATA_W  store data
- dm_rdata  output  DATA_W  load data, registered
- dm_done  output  1  one-cycle pulse: data access complete
- stall_if  output  1  if_req && !if_done
- stall_mem  output  1  (dm_read || dm_write) && !dm_done
- mem_req, mem_we  output  1 each  memory request / write enable
- mem_addr  output  ADDR_W; mem_wdata  output  DATA_W
- mem_rdata  input  DATA_W; mem_ready  input  1  memory completion strobe

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE transitions:
  - Data request pending → BUSY_D.
  - Else if_req → BUSY_I.
  - Else stay in IDLE.
- On entering BUSY_x, latch address, write enable and write data into output registers, and assert mem_req. All of these are held stable until the cycle with mem_ready=1.
- BUSY_x with mem_ready=1:
  - Capture mem_rdata into if_rdata (BUSY_I) or dm_rdata (BUSY_D, reads only).
  - Go to RESP_x.
- RESP_x:
  - Pulse x_done for one cycle, then return to IDLE.
  - No arbitration happens in RESP. Requesters drop or change their request on the cycle after done.
- dm_read and dm_write both high: treated as a write. mem_we=1, dm_rdata unchanged.
- Stores leave dm_rdata unchanged. Address low bits are passed through unmodified.
- Input changes during BUSY are ignored; the latched request completes.
- Reset values:
  - State = IDLE.
  - mem_req, mem_we, if_done, dm_done = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Guard counter = 0.
- Reset mid-transaction: mem_req drops asynchronously and the access is abandoned. No done pulse is produced.

## Timing
- Request seen in IDLE at cycle 0 → mem_req=1 from cycle 1.
- Memory with latency L (mem_ready at cycle 1+L, L≥0) → x_done at cycle 2+L.
- Minimum access turnaround is 3 cycles (L=0, i.e. mem_ready in the first BUSY cycle).
- Next grant can start its IDLE decision at cycle 3+L.
- stall_if and stall_mem are combinational from the request inputs and the registered done signals. A stage is stalled every cycle of its pending access except the done cycle.
- mem_ready outside BUSY is ignored.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each data grant made while if_req=1.
  - When the count equals MAX_D_GRANTS and if_req=1, IDLE grants IF even if a data request is pending.
  - The counter clears on an IF grant, or when if_req=0 in IDLE.
- Undefined:
  - Strict data priority; the counter logic is absent.
  - MAX_D_GRANTS is unused.

## Structure
- Package mips_mem_pkg holds:
  - the arbiter state enumeration
  - ADDR_W/DATA_W default constants
  - the counter width derived from MAX_D_GRANTS
- Sub-module arb_starve_guard: the counter and force-IF compare. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- IF read only, if_addr=0x0000_0040, memory L=2 returning 0x8C08_0004 → mem_req cycles 1–3, if_done at cycle 4, if_rdata=0x8C08_0004, stall_if high cycles 0–3.
- Simultaneous if_req and dm_read at 0x100 (L=0) → data granted first; dm_done at cycle 2; IF granted from cycle 3; if_done at cycle 5.
- Store dm_write, dm_addr=0x200, dm_wdata=0xDEAD_BEEF → mem_we=1, mem_addr=0x200, mem_wdata held until mem_ready; dm_rdata unchanged.
- Assert rst during BUSY_D (L=5, at cycle 3) → mem_req=0 immediately; no dm_done; state IDLE; a fresh request after reset completes normally.
- With ARB_STARVE_GUARD_EN, MAX_D_GRANTS=4, dm_read held continuously and if_req=1 → four data grants, then one IF grant. Without the macro, IF is never granted.
- dm_read and dm_write both 1 → write performed (mem_we=1); dm_done pulses once.
